// File: rtl/cpu_controller_if.sv
// Controller <-> datapath bundle: IR contents and memory handshake in,
// datapath/PC/memory strobes out. master = controller, slave = datapath.
interface cpu_controller_if;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned PC_W    = 9;
   localparam int unsigned REG_W   = 3;

   logic [INSTR_W-1:0] instr;
   logic               mem_ready;

   logic               reset_pc;
   logic               load_pc;
   logic               load_ir;
   logic               load_addr;
   logic               addr_sel;
   logic [1:0]         mem_cmd;
   logic               write;
   logic               loada;
   logic               loadb;
   logic               loadc;
   logic               loads;
   logic               loadm;
   logic               asel;
   logic               bsel;
   logic               csel;
   logic [3:0]         vsel;
   logic [REG_W-1:0]   reg_w;
   logic [REG_W-1:0]   reg_a;
   logic [REG_W-1:0]   reg_b;
   logic [1:0]         op;
   logic [1:0]         shift;
   logic               halted;
   logic [PC_W-1:0]    reset_pc_val;

   modport master (
      input  instr, mem_ready,
      output reset_pc, load_pc, load_ir, load_addr, addr_sel, mem_cmd,
             write, loada, loadb, loadc, loads, loadm, asel, bsel, csel,
             vsel, reg_w, reg_a, reg_b, op, shift, halted, reset_pc_val
   );

   modport slave (
      output instr, mem_ready,
      input  reset_pc, load_pc, load_ir, load_addr, addr_sel, mem_cmd,
             write, loada, loadb, loadc, loads, loadm, asel, bsel, csel,
             vsel, reg_w, reg_a, reg_b, op, shift, halted, reset_pc_val
   );
endinterface

// File: rtl/cpu_controller.sv
// Moore sequencer for the 16-bit register/ALU datapath: fetch, decode and
// execute one instruction at a time.
// Optional macro CTRL_MEM_WAIT_EN: memory states stretch until mem_ready=1.
// Outputs are registered from the next state, so they line up with the
// state register and clear asynchronously on reset.
module cpu_controller #(
   parameter logic [8:0] RESET_PC = 9'd0
) (
   input logic              clk,
   input logic              rst_n,
   cpu_controller_if.master bus
);
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   typedef enum logic [3:0] {
      S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WIMM, S_GA, S_GB,
      S_EX, S_WB, S_ADDR, S_LDM, S_LWB, S_STD, S_STM, S_HALT
   } state_t;

   typedef struct packed {
      logic       reset_pc;
      logic       load_pc;
      logic       load_ir;
      logic       load_addr;
      logic       addr_sel;
      logic [1:0] mem_cmd;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       loadm;
      logic       asel;
      logic       bsel;
      logic       csel;
      logic [3:0] vsel;
      logic [2:0] reg_w;
      logic [2:0] reg_a;
      logic [2:0] reg_b;
      logic [1:0] op;
      logic [1:0] shift;
      logic       halted;
   } ctrl_t;

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   run_q;

   logic [2:0] opc, rn, rd, rm;
   logic [1:0] alu_op, sh;

   assign opc    = bus.instr[15:13];
   assign alu_op = bus.instr[12:11];
   assign rn     = bus.instr[10:8];
   assign rd     = bus.instr[7:5];
   assign sh     = bus.instr[4:3];
   assign rm     = bus.instr[2:0];

   // State, first-cycle flag and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RST;
         run_q   <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         ctrl_q  <= ctrl_d;
      end
   end

   // Next-state dispatch and output decode of the state being entered
   always_comb begin
      state_d = state_q;
      ctrl_d  = '0;

      case (state_q)
         S_RST:  state_d = run_q ? S_IF1 : S_RST;
         S_IF1:  state_d = S_IF2;
`ifdef CTRL_MEM_WAIT_EN
         S_IF2:  state_d = bus.mem_ready ? S_UPD : S_IF2;
`else
         S_IF2:  state_d = S_UPD;
`endif
         S_UPD:  state_d = S_DEC;
         S_DEC: begin
            if (opc == OPC_MOV && alu_op == 2'b10)      state_d = S_WIMM;
            else if (opc == OPC_MOV && alu_op == 2'b00) state_d = S_GB;
            else if (opc == OPC_ALU)                    state_d = (alu_op == 2'b11) ? S_GB : S_GA;
            else if ((opc == OPC_LDR || opc == OPC_STR) && alu_op == 2'b00)
                                                        state_d = S_GA;
            else if (opc == OPC_HALT)                   state_d = S_HALT;
            else                                        state_d = S_IF1;
         end
         S_WIMM: state_d = S_IF1;
         S_GA:   state_d = (opc == OPC_LDR || opc == OPC_STR) ? S_ADDR : S_GB;
         S_GB:   state_d = S_EX;
         S_EX:   state_d = (opc == OPC_ALU && alu_op == 2'b01) ? S_IF1 : S_WB;
         S_WB:   state_d = S_IF1;
         S_ADDR: state_d = (opc == OPC_LDR) ? S_LDM : S_STD;
         S_LDM:  state_d = S_LWB;
         S_STD:  state_d = S_STM;
`ifdef CTRL_MEM_WAIT_EN
         S_LWB:  state_d = bus.mem_ready ? S_IF1 : S_LWB;
         S_STM:  state_d = bus.mem_ready ? S_IF1 : S_STM;
`else
         S_LWB:  state_d = S_IF1;
         S_STM:  state_d = S_IF1;
`endif
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase

      ctrl_d.reg_a = rn;
      ctrl_d.reg_b = rm;
      ctrl_d.reg_w = rd;

      case (state_d)
         S_RST: begin
            ctrl_d.reset_pc = 1'b1;
            ctrl_d.load_pc  = 1'b1;
         end
         S_IF1: begin
            ctrl_d.addr_sel = 1'b1;
            ctrl_d.mem_cmd  = 2'b01;
         end
         S_IF2: begin
            ctrl_d.addr_sel = 1'b1;
            ctrl_d.mem_cmd  = 2'b01;
            ctrl_d.load_ir  = 1'b1;
         end
         S_UPD:  ctrl_d.load_pc = 1'b1;
         S_WIMM: begin
            ctrl_d.reg_w = rn;
            ctrl_d.vsel  = 4'b0100;
            ctrl_d.write = 1'b1;
         end
         S_GA:   ctrl_d.loada = 1'b1;
         S_GB:   ctrl_d.loadb = 1'b1;
         S_EX: begin
            ctrl_d.shift = sh;
            ctrl_d.op    = (opc == OPC_ALU) ? alu_op : 2'b00;
            ctrl_d.asel  = (opc == OPC_MOV);
            if (opc == OPC_ALU && alu_op == 2'b01) ctrl_d.loads = 1'b1;
            else                                   ctrl_d.loadc = 1'b1;
         end
         S_WB: begin
            ctrl_d.vsel  = 4'b0001;
            ctrl_d.write = 1'b1;
         end
         S_ADDR: begin
            ctrl_d.bsel      = 1'b1;
            ctrl_d.loadm     = 1'b1;
            ctrl_d.load_addr = 1'b1;
         end
         S_LDM:  ctrl_d.mem_cmd = 2'b01;
         S_LWB: begin
            ctrl_d.mem_cmd = 2'b01;
            ctrl_d.vsel    = 4'b0010;
            ctrl_d.write   = 1'b1;
         end
         S_STD: begin
            ctrl_d.reg_b = rd;
            ctrl_d.csel  = 1'b1;
            ctrl_d.loadc = 1'b1;
         end
         S_STM:  ctrl_d.mem_cmd = 2'b10;
         S_HALT: ctrl_d.halted  = 1'b1;
         default: ;
      endcase
   end

`ifdef CTRL_MEM_WAIT_EN
   // IR load and memory writeback commit only on the ready cycle
   assign bus.load_ir = ctrl_q.load_ir & bus.mem_ready;
   assign bus.write   = ctrl_q.write & ((state_q != S_LWB) | bus.mem_ready);
`else
   logic unused_mem_ready;
   assign unused_mem_ready = bus.mem_ready;
   assign bus.load_ir      = ctrl_q.load_ir;
   assign bus.write        = ctrl_q.write;
`endif

   assign bus.reset_pc     = ctrl_q.reset_pc;
   assign bus.load_pc      = ctrl_q.load_pc;
   assign bus.load_addr    = ctrl_q.load_addr;
   assign bus.addr_sel     = ctrl_q.addr_sel;
   assign bus.mem_cmd      = ctrl_q.mem_cmd;
   assign bus.loada        = ctrl_q.loada;
   assign bus.loadb        = ctrl_q.loadb;
   assign bus.loadc        = ctrl_q.loadc;
   assign bus.loads        = ctrl_q.loads;
   assign bus.loadm        = ctrl_q.loadm;
   assign bus.asel         = ctrl_q.asel;
   assign bus.bsel         = ctrl_q.bsel;
   assign bus.csel         = ctrl_q.csel;
   assign bus.vsel         = ctrl_q.vsel;
   assign bus.reg_w        = ctrl_q.reg_w;
   assign bus.reg_a        = ctrl_q.reg_a;
   assign bus.reg_b        = ctrl_q.reg_b;
   assign bus.op           = ctrl_q.op;
   assign bus.shift        = ctrl_q.shift;
   assign bus.halted       = ctrl_q.halted;
   assign bus.reset_pc_val = RESET_PC;
endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed and random instructions checked cycle
// by cycle against an instruction-level model of the control sequence.
module tb_cpu_controller;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cpu_controller_if bus ();

   cpu_controller #(.RESET_PC(9'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       reset_pc, load_pc, load_ir, load_addr, addr_sel;
      logic [1:0] mem_cmd;
      logic       write, loada, loadb, loadc, loads, loadm, asel, bsel, csel;
      logic [3:0] vsel;
      logic [2:0] reg_w, reg_a, reg_b;
      logic [1:0] op, shift;
      logic       halted;
   } vec_t;

   int    n_assert = 0;
   int    n_fail   = 0;
   vec_t  exp_q[$];
   string tag_q[$];

   function automatic vec_t observe();
      vec_t v;
      v.reset_pc = bus.reset_pc;   v.load_pc  = bus.load_pc;
      v.load_ir  = bus.load_ir;    v.load_addr = bus.load_addr;
      v.addr_sel = bus.addr_sel;   v.mem_cmd  = bus.mem_cmd;
      v.write    = bus.write;      v.loada    = bus.loada;
      v.loadb    = bus.loadb;      v.loadc    = bus.loadc;
      v.loads    = bus.loads;      v.loadm    = bus.loadm;
      v.asel     = bus.asel;       v.bsel     = bus.bsel;
      v.csel     = bus.csel;       v.vsel     = bus.vsel;
      v.reg_w    = bus.reg_w;      v.reg_a    = bus.reg_a;
      v.reg_b    = bus.reg_b;      v.op       = bus.op;
      v.shift    = bus.shift;      v.halted   = bus.halted;
      return v;
   endfunction

   // Default register selects taken from an instruction word
   function automatic vec_t sel_only(input logic [15:0] ins);
      vec_t v = '0;
      v.reg_a = ins[10:8];
      v.reg_b = ins[2:0];
      v.reg_w = ins[7:5];
      return v;
   endfunction

   function automatic void push(input vec_t v, input string t);
      exp_q.push_back(v);
      tag_q.push_back(t);
   endfunction

   // Expected per-cycle controls from IF1 to the end of one instruction
   function automatic void model(input logic [15:0] prev, input logic [15:0] cur);
      vec_t v;
      logic [2:0] opc = cur[15:13];
      logic [1:0] o   = cur[12:11];
      logic is_movi = (opc == 3'b110) && (o == 2'b10);
      logic is_movr = (opc == 3'b110) && (o == 2'b00);
      logic is_alu  = (opc == 3'b101);
      logic is_cmp  = is_alu && (o == 2'b01);
      logic is_mem  = ((opc == 3'b011) || (opc == 3'b100)) && (o == 2'b00);
      exp_q.delete();
      tag_q.delete();
      v = sel_only(prev); v.addr_sel = 1'b1; v.mem_cmd = 2'b01; push(v, "if1");
      v.load_ir = 1'b1; push(v, "if2");
      v = sel_only(cur); v.load_pc = 1'b1; push(v, "upd");
      v = sel_only(cur); push(v, "dec");
      if (is_movi) begin
         v = sel_only(cur); v.reg_w = cur[10:8]; v.vsel = 4'b0100; v.write = 1'b1;
         push(v, "wimm");
      end else if (is_movr || is_alu) begin
         if (is_alu && o != 2'b11) begin
            v = sel_only(cur); v.loada = 1'b1; push(v, "ga");
         end
         v = sel_only(cur); v.loadb = 1'b1; push(v, "gb");
         v = sel_only(cur); v.shift = cur[4:3]; v.op = is_alu ? o : 2'b00;
         v.asel = is_movr;
         if (is_cmp) v.loads = 1'b1; else v.loadc = 1'b1;
         push(v, "ex");
         if (!is_cmp) begin
            v = sel_only(cur); v.vsel = 4'b0001; v.write = 1'b1; push(v, "wb");
         end
      end else if (is_mem) begin
         v = sel_only(cur); v.loada = 1'b1; push(v, "ga");
         v = sel_only(cur); v.bsel = 1'b1; v.loadm = 1'b1; v.load_addr = 1'b1;
         push(v, "addr");
         if (opc == 3'b011) begin
            v = sel_only(cur); v.mem_cmd = 2'b01; push(v, "ldm");
            v.vsel = 4'b0010; v.write = 1'b1; push(v, "lwb");
         end else begin
            v = sel_only(cur); v.reg_b = cur[7:5]; v.csel = 1'b1; v.loadc = 1'b1;
            push(v, "std");
            v = sel_only(cur); v.mem_cmd = 2'b10; push(v, "stm");
         end
      end else if (opc == 3'b111) begin
         v = sel_only(cur); v.halted = 1'b1;
         for (int k = 0; k < 6; k++) push(v, "halt");
      end
   endfunction

   task automatic check(input string tag, input vec_t exp);
      vec_t obs = observe();
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      n_assert++;
      assert ($countones(obs.vsel) <= 1) else begin
         n_fail++;
         $error("FAIL %s_vsel: observed vsel %b expected at most one bit set", tag, obs.vsel);
      end
   endtask

   // Run one instruction from IF1; ncheck=0 checks every cycle of it
   task automatic run_instr(input logic [15:0] cur, input int ncheck);
      int n;
      model(bus.instr, cur);
      n = (ncheck == 0) ? exp_q.size() : ncheck;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check(tag_q[i], exp_q[i]);
`ifndef CTRL_MEM_WAIT_EN
         bus.mem_ready = 1'($urandom_range(0, 1));
`endif
         if (i == 1) bus.instr = cur;
      end
   endtask

   task automatic do_reset(input string tag);
      vec_t v;
      #2 rst_n = 1'b0;
      #1 check({tag, "_async"}, '0);
      @(negedge clk);
      check({tag, "_held"}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      v = sel_only(bus.instr); v.reset_pc = 1'b1; v.load_pc = 1'b1;
      check({tag, "_rst"}, v);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] ins = 16'($urandom);
      logic [2:0]  nop_opc;
      case ($urandom_range(0, 9))
         0: ins[15:11] = 5'b11010;
         1: ins[15:11] = 5'b11000;
         2: ins[15:11] = 5'b10100;
         3: ins[15:11] = 5'b10101;
         4: ins[15:11] = 5'b10110;
         5: ins[15:11] = 5'b10111;
         6: ins[15:11] = 5'b01100;
         7: ins[15:11] = 5'b10000;
         8: begin
            nop_opc = 3'($urandom_range(0, 2));
            ins[15:13] = nop_opc;
         end
         default: begin
            ins[15:13] = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b100;
            ins[12:11] = 2'($urandom_range(1, 3));
         end
      endcase
      return ins;
   endfunction

`ifdef CTRL_MEM_WAIT_EN
   // Fetch with IF2 held off for nwait cycles by mem_ready=0
   task automatic run_wait(input logic [15:0] cur, input int nwait);
      vec_t v;
      model(bus.instr, cur);
      @(negedge clk);
      check(tag_q[0], exp_q[0]);
      bus.mem_ready = 1'b0;
      for (int k = 0; k < nwait; k++) begin
         @(negedge clk);
         v = exp_q[1]; v.load_ir = 1'b0;
         check("if2_wait", v);
      end
      bus.mem_ready = 1'b1;
      #1 check("if2_ready", exp_q[1]);
      bus.instr = cur;
      for (int i = 2; i < exp_q.size(); i++) begin
         @(negedge clk);
         check(tag_q[i], exp_q[i]);
      end
   endtask
`endif

   initial begin
      vec_t v;
      bus.instr     = 16'hD107;
      bus.mem_ready = 1'b1;
      rst_n         = 1'b0;
      @(negedge clk);
      check("reset_state", '0);
      n_assert++;
      assert (bus.reset_pc_val === 9'd0) else begin
         n_fail++;
         $error("FAIL reset_pc_val: observed %h expected 000", bus.reset_pc_val);
      end
      rst_n = 1'b1;
      @(negedge clk);
      v = sel_only(16'hD107); v.reset_pc = 1'b1; v.load_pc = 1'b1;
      check("rst", v);

      run_instr(16'hD107, 0);
      run_instr(16'hA148, 0);
      run_instr(16'hA900, 0);
      run_instr(16'h6042, 0);
      run_instr(16'h8042, 0);
      for (int t = 0; t < 60; t++) run_instr(rand_instr(), 0);
      run_instr(16'hD107, 0);

      run_instr(16'hE000, 0);
      do_reset("reset_from_halt");
      run_instr(16'h6042, 7);
      do_reset("reset_mid_ldm");
      run_instr(16'hA148, 0);
`ifdef CTRL_MEM_WAIT_EN
      bus.mem_ready = 1'b1;
      run_wait(16'hD107, 3);
`endif
      run_instr(16'hA900, 0);
      @(negedge clk);
      v = sel_only(16'hA900); v.addr_sel = 1'b1; v.mem_cmd = 2'b01;
      check("final_if1", v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Moore FSM that sequences the 16-bit register/ALU datapath.
- Fetches instructions from memory, decodes the IR, and drives every datapath load/select strobe plus the memory command.
- Sits between the instruction register, the PC/address logic and the datapath.
- One instruction is in flight at a time; there is no pipelining.

Parameters:
- RESET_PC, 9'd0, value the PC logic loads when reset_pc is asserted.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  current IR contents. Fields: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0].
- mem_ready  in  1  memory done. Used only with CTRL_MEM_WAIT_EN; ignored otherwise.
- reset_pc, load_pc, load_ir, load_addr  out  1 each  PC/IR/address-register strobes.
- addr_sel  out  1  memory address source: 1=PC, 0=data_address.
- mem_cmd  out  2  00=none, 01=read, 10=write.
- write, loada, loadb, loadc, loads, loadm, asel, bsel, csel  out  1 each  datapath controls.
- vsel  out  4  one-hot writeback select: [0]=C, [1]=mdata, [2]=sximm8, [3]=PC.
- reg_w, reg_a, reg_b  out  3 each  register selects.
- op, shift  out  2 each  ALU op and shifter code.
- halted  out  1  high in HALT.

Behaviour:
- rst_n low: state=RST immediately. All outputs 0, vsel=0000, mem_cmd=00.
- Reset mid-instruction aborts it; no register or memory write completes.
- Any strobe not listed for a state is 0.
- Default selects: reg_a=Rn, reg_b=Rm, reg_w=Rd, shift=00, op=00.
- Fetch sequence:
  - RST: reset_pc=1, load_pc=1 -> IF1.
  - IF1: addr_sel=1, mem_cmd=01 -> IF2.
  - IF2: addr_sel=1, mem_cmd=01, load_ir=1 -> UPD.
  - UPD: load_pc=1 -> DEC.
- DEC dispatch:
  - 110/10 MOV imm -> WIMM.
  - 110/00 MOV reg -> GB.
  - 101/xx ALU -> GA, except op=11 MVN -> GB.
  - 011/00 LDR -> GA.
  - 100/00 STR -> GA.
  - 111 -> HALT.
  - Anything else: NOP -> IF1.
- WIMM: reg_w=Rn, vsel=0100, write=1 -> IF1.
- GA: loada=1. Next state: LDR/STR -> ADDR; otherwise -> GB.
- GB: loadb=1 -> EX.
- EX:
  - shift=sh.
  - op=instr[12:11] for 101; op=00 for MOV reg.
  - asel=1 for MOV reg.
  - CMP (101/01): loads=1, loadc=0 -> IF1.
  - Otherwise: loadc=1 -> WB.
- WB: vsel=0001, write=1, reg_w=Rd -> IF1.
- ADDR: bsel=1, op=00, loadm=1, load_addr=1. Next state: LDR -> LDM; STR -> STD.
- LDM: addr_sel=0, mem_cmd=01 -> LWB.
- LWB: addr_sel=0, mem_cmd=01, vsel=0010, reg_w=Rd, write=1 -> IF1.
- STD: reg_b=Rd, csel=1, loadc=1 -> STM.
- STM: addr_sel=0, mem_cmd=10 -> IF1.
- HALT: halted=1. Holds until rst_n is asserted; ignores instr.
- Latency from IF1 to the next IF1:
  - MOV imm: 5 cycles.
  - MOV reg, MVN: 7.
  - CMP: 7.
  - ADD, AND: 8.
  - LDR, STR: 8.
- vsel is never multi-hot; it is 0000 in every state except WIMM, WB and LWB.

Optional Feature:
- Macro: CTRL_MEM_WAIT_EN.
- Defined:
  - IF2, LWB and STM hold the state and keep mem_cmd/addr_sel asserted while mem_ready=0.
  - load_ir (IF2) and write (LWB) pulse only in the cycle mem_ready=1, then the FSM advances.
  - Reset during a wait aborts the access.
- Undefined: mem_ready is ignored; every memory state is exactly 1 cycle.

Test Plan:
- Reset release with instr=0xD107 (MOV R1,#7) -> RST, IF1, IF2, UPD, DEC; then one cycle with write=1, reg_w=1, vsel=0100; then IF1 with mem_cmd=01.
- instr=0xA148 (ADD R2,R1,R0,LSL#1) -> loada with reg_a=1; loadb with reg_b=0; EX with shift=01, op=00, loadc=1; WB with reg_w=2, vsel=0001, write=1. 8 cycles total.
- instr=0xA900 (CMP R1,R0) -> EX with loads=1, loadc=0; no write pulse in the instruction; back to IF1 after 7 cycles.
- instr=0x6042 (LDR R2,[R0,#2]) -> ADDR with bsel=1, loadm=1; LDM/LWB with addr_sel=0, mem_cmd=01; LWB with vsel=0010, reg_w=2, write=1.
- instr=0x8042 (STR R2,[R0,#2]) -> STD with reg_b=2, csel=1, loadc=1; STM with mem_cmd=10; write stays 0 throughout.
- instr=0xE000 -> halted=1 indefinitely. Drop rst_n mid-LDM -> all outputs 0 asynchronously. With CTRL_MEM_WAIT_EN and mem_ready=0 for 3 cycles in IF2 -> state held and load_ir=0 until mem_ready=1.
